// File: rtl/inst_fetch_ctrl_pkg.sv
// inst_fetch_ctrl_pkg: shared state/issue-mode encodings, reset PC default and pop decoding for the fetch sequencer
package inst_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef enum logic {
        SINGLE_ISSUE = 1'b0,
        DUAL_ISSUE   = 1'b1
    } issue_mode_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // Number of buffer entries the issue stage consumed this cycle
    function automatic logic [1:0] pop_count(input logic issue, input logic mode);
        return issue ? ((mode == DUAL_ISSUE) ? 2'd2 : 2'd1) : 2'd0;
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_credit_cnt.sv
// fetch_credit_cnt: mirror of instruction buffer occupancy, saturating at 0 and BUF_DEPTH, emptied on flush
module fetch_credit_cnt #(
    parameter int BUF_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push1_i,
    input  logic                       push2_i,
    input  logic [1:0]                 pop_i,
    output logic [$clog2(BUF_DEPTH):0] occ_o
);
    localparam int OW = $clog2(BUF_DEPTH) + 1;
    localparam int GW = OW + 2;

    logic [OW-1:0] occ_q, occ_d;
    logic [GW-1:0] gross, net;

    // Pushes land before pops; the result is clamped so the mirror can never wrap
    always_comb begin
        gross = GW'(occ_q) + GW'(push1_i) + GW'(push2_i);
        net   = gross - GW'(pop_i);
        occ_d = (gross < GW'(pop_i)) ? '0 :
                (net > GW'(BUF_DEPTH)) ? OW'(BUF_DEPTH) : OW'(net);
        if (flush_i) occ_d = '0;
    end

    // Occupancy register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) occ_q <= '0;
        else      occ_q <= occ_d;
    end

    assign occ_o = occ_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: fetch sequencer issuing aligned ICache requests, tracking outstanding responses and
// discarding stale ones after a flush. Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH       = 8,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic [31:0]                flush_pc_i,
    input  logic                       issue_i,
    input  logic                       issue_mode_i,
    output logic                       icache_req_o,
    output logic [31:0]                icache_req_addr_o,
    input  logic                       icache_req_ready_i,
    input  logic                       icache_inst1_valid_i,
    input  logic                       icache_inst2_valid_i,
    output logic                       buf_push1_o,
    output logic                       buf_push2_o,
    output logic [$clog2(BUF_DEPTH):0] occupancy_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]                perf_fetch_cnt_o,
    output logic [31:0]                perf_stall_cnt_o,
`endif
    output logic                       stall_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outst_q, outst_d, disc_q, disc_d;
    logic          can_issue, transfer, response, live;

    // Each outstanding request may return two instructions, so reserve that room before asking for more
    always_comb begin
        can_issue    = (32'(outst_q) < 32'(MAX_OUTSTANDING)) &&
                       (32'(occupancy_o) + 32'(outst_q) * 32'd2 + 32'd2 <= 32'(BUF_DEPTH));
        icache_req_o = (state_q == RUN) && !flush_i && can_issue;
        stall_o      = (state_q == RUN) && !flush_i && !can_issue;
        transfer     = icache_req_o && icache_req_ready_i;
        response     = icache_inst1_valid_i && (disc_q != '0 || outst_q != '0);
        live         = (disc_q == '0) && (outst_q != '0) && !flush_i;
        buf_push1_o  = icache_inst1_valid_i && live;
        buf_push2_o  = icache_inst2_valid_i && live;
    end

    // PC, outstanding and discard bookkeeping; a flush turns everything in flight into discards
    always_comb begin
        pc_d    = pc_q;
        outst_d = outst_q;
        disc_d  = disc_q;
        if (flush_i) begin
            pc_d    = flush_pc_i;
            outst_d = '0;
            disc_d  = outst_q + disc_q + CW'(transfer) - CW'(response);
        end else begin
            pc_d    = transfer ? pc_q + (pc_q[2] ? 32'd4 : 32'd8) : pc_q;
            outst_d = outst_q + CW'(transfer) - CW'(response && disc_q == '0);
            disc_d  = disc_q - CW'(response && disc_q != '0);
        end
    end

    // Sequencer: a flush lands in DRAIN only while stale responses remain to be swallowed
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = (disc_d != '0) ? DRAIN : RUN;
            DRAIN:   state_d = (disc_d == '0) ? RUN : DRAIN;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = (disc_d == '0) ? RUN : DRAIN;
    end

    // Control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            outst_q <= '0;
            disc_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            disc_q  <= disc_d;
        end
    end

    assign icache_req_addr_o = pc_q;

    fetch_credit_cnt #(
        .BUF_DEPTH(BUF_DEPTH)
    ) u_credit (
        .clk    (clk),
        .rst    (rst),
        .flush_i(flush_i),
        .push1_i(buf_push1_o),
        .push2_i(buf_push2_o),
        .pop_i  (pop_count(issue_i, issue_mode_i)),
        .occ_o  (occupancy_o)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d, perf_stall_q, perf_stall_d;

    // Free-running wrap-around counters; flush leaves them alone
    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(buf_push1_o) + 32'(buf_push2_o);
        perf_stall_d = perf_stall_q + 32'(stall_o);
    end

    // Perf counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule
